regfile_fwd: RTL and testbench

REGFILE_FWD -- requirements
Module: regfile_fwd

---
 rtl/regfile_fwd_pkg.sv | 17 +
 rtl/regfile_fwd_sel.sv | 43 ++++
 rtl/regfile_fwd.sv | 114 +++++++++++
 tb/tb_regfile_fwd.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared types and default sizes for the forwarding register file.
// Stage tags carry a fixed-width address so the struct stays parameter-free.
package regfile_fwd_pkg;

  localparam int DW_DEF    = 16;
  localparam int NREG_DEF  = 8;
  localparam int NRD_DEF   = 2;
  localparam int DEPTH_DEF = 3;
  localparam int AW_MAX    = 8;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [AW_MAX-1:0] waddr;
  } stg_tag_t;

endpackage

// File: rtl/regfile_fwd_sel.sv
// Per-read-port operand select: the youngest valid writer to the source wins,
// otherwise the architectural value is used.
module regfile_fwd_sel
  import regfile_fwd_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = 3,
  parameter int DEPTH  = DEPTH_DEF,
  parameter bit BYPASS = 1'b0
) (
  input  stg_tag_t [DEPTH-1:0]         tags,
  input  logic     [DEPTH-1:0][DW-1:0] stg_data,
  input  logic     [DEPTH-1:0]         stg_rdy,
  input  logic     [AW-1:0]            rd_addr,
  input  logic                         addr_ok,
  input  logic     [DW-1:0]            gr_data,
  output logic     [DW-1:0]            data,
  output logic                         blk
);

  logic          hit;
  logic          hit_rdy;
  logic [DW-1:0] fwd;

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b1;
    fwd     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (addr_ok && tags[i].valid && tags[i].we && (tags[i].waddr == AW_MAX'(rd_addr))) begin
        hit     = 1'b1;
        hit_rdy = stg_rdy[i];
        fwd     = stg_data[i];
      end
    end
  end

  // Without bypass any in-flight writer interlocks the reader until commit.
  assign data = (BYPASS && hit) ? fwd : gr_data;
  assign blk  = BYPASS ? (hit && !hit_rdy) : hit;

endmodule

// File: rtl/regfile_fwd.sv
// Register file with in-flight tag pipeline, operand forwarding and interlock.
// Define REGFILE_FWD_BYPASS_EN to forward stage results; otherwise readers stall until commit.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int NREG  = NREG_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic                  iss_we,
  input  logic [AW-1:0]         iss_waddr,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DW-1:0]     rd_data,
  output logic                  stall,
  input  logic [DEPTH*DW-1:0]   stg_data,
  input  logic [DEPTH-1:0]      stg_rdy,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DW-1:0]         dbg_data,
  output logic                  commit
);

`ifdef REGFILE_FWD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0]             we_q;
  logic [DEPTH-1:0][AW_MAX-1:0] waddr_q;
  stg_tag_t [DEPTH-1:0]         tags;
  logic [NREG-1:0][DW-1:0]      gr_q;
  logic [DEPTH-1:0][DW-1:0]     sdat;
  logic [NRD-1:0][DW-1:0]       rdat;
  logic [NRD-1:0]               blk;
  logic                         issue;
  logic                         wb_fire;
  logic                         wb_ok;
  logic                         wb_block;
  logic [AW-1:0]                wb_idx;

  assign sdat = stg_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    assign tags[i] = '{valid: vld_pipe[i], we: we_q[i], waddr: waddr_q[i]};
  end

  assign issue    = iss_valid && !stall && !flush;
  assign wb_idx   = waddr_q[DEPTH-1][AW-1:0];
  assign wb_ok    = int'(waddr_q[DEPTH-1]) < NREG;
  assign wb_fire  = en && vld_pipe[DEPTH-1] && we_q[DEPTH-1] && stg_rdy[DEPTH-1];
  assign wb_block = vld_pipe[DEPTH-1] && we_q[DEPTH-1] && !stg_rdy[DEPTH-1];
  assign commit   = wb_fire && !reset;

  // Flush kills everything younger than writeback; the retiring stage still commits below.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
    end else if (en) begin
      vld_pipe <= flush ? '0 : {vld_pipe[DEPTH-2:0], issue};
      we_q     <= {we_q[DEPTH-2:0], iss_we};
      waddr_q  <= {waddr_q[DEPTH-2:0], AW_MAX'(iss_waddr)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) gr_q <= '0;
    else if (wb_fire && wb_ok) gr_q[wb_idx] <= sdat[DEPTH-1];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] ra;
    logic          ok;
    logic [DW-1:0] grd;

    assign ra  = rd_addr[k*AW +: AW];
    assign ok  = int'(ra) < NREG;
    assign grd = ok ? gr_q[ra] : '0;

    regfile_fwd_sel #(
      .DW     (DW),
      .AW     (AW),
      .DEPTH  (DEPTH),
      .BYPASS (BYPASS)
    ) u_sel (
      .tags     (tags),
      .stg_data (sdat),
      .stg_rdy  (stg_rdy),
      .rd_addr  (ra),
      .addr_ok  (ok),
      .gr_data  (grd),
      .data     (rdat[k]),
      .blk      (blk[k])
    );
  end

  assign rd_data  = rdat;
  assign stall    = (iss_valid && |blk) || wb_block;
  assign dbg_data = (int'(dbg_addr) < NREG) ? gr_q[dbg_addr] : '0;

  // The requester must drop en while the writeback result is outstanding.
  a_wb_rdy: assert property (@(posedge clock) disable iff (reset)
    !(en && vld_pipe[DEPTH-1] && we_q[DEPTH-1] && !stg_rdy[DEPTH-1]));

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd at DW=16, NREG=8, NRD=2, DEPTH=3.
module tb_regfile_fwd;

`ifdef REGFILE_FWD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [15:0] K = 16'h1234;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, flush = 1'b0, iss_valid = 1'b0, iss_we = 1'b0;
  logic [2:0]  iss_waddr = '0;
  logic [5:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        stall;
  logic [47:0] stg_data = '0;
  logic [2:0]  stg_rdy = 3'b111;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        commit;

  int checks = 0;
  int errors = 0;

  regfile_fwd dut (
    .clock(clock), .reset(reset), .en(en), .flush(flush),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr),
    .rd_addr(rd_addr), .rd_data(rd_data), .stall(stall),
    .stg_data(stg_data), .stg_rdy(stg_rdy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .commit(commit)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          en, fl, iv, we;
    int          wa, ra0, ra1;
    bit [2:0]    rdy;
    logic [15:0] d0, d1, d2;
    int          da;
    logic [15:0] e0, e1, edbg;
    bit          est, ecm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit e, f, v, w, int wa, a0, a1, bit [2:0] rdy,
                              logic [15:0] d0, d1, d2, int da,
                              logic [15:0] e0, e1, edbg, bit est, ecm);
    vec_t r;
    r.en = e; r.fl = f; r.iv = v; r.we = w; r.wa = wa; r.ra0 = a0; r.ra1 = a1;
    r.rdy = rdy; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.da = da;
    r.e0 = e0; r.e1 = e1; r.edbg = edbg; r.est = est; r.ecm = ecm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit e, f, v, w, input int wa, a0, a1, input bit [2:0] rdy,
                     input logic [15:0] d0, d1, d2, input int da);
    @(negedge clock);
    en = e; flush = f; iss_valid = v; iss_we = w; iss_waddr = 3'(wa);
    rd_addr = {3'(a1), 3'(a0)}; stg_rdy = rdy; stg_data = {d2, d1, d0};
    dbg_addr = 3'(da);
    #1;
  endtask

  task automatic idle(input int a0, input int da);
    cyc(1, 0, 0, 0, 0, a0, 0, 3'b111, K, K, K, da);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; en = 1'b1; flush = 1'b1; iss_valid = 1'b0; stg_rdy = 3'b111;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Reset state and debug sweep
    do_reset();
    @(negedge clock);
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    #1 chk("reset_commit", 32'(commit), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(0, i);
      chk($sformatf("rst_dbg%0d", i), 32'(dbg_data), 0);
      chk($sformatf("rst_commit%0d", i), 32'(commit), 0);
    end
    chk("rst_stall", 32'(stall), 0);

    // Table: writeback, commit order, flush, en hold (forwarding-neutral reads)
    do_reset();
    tv.push_back(mk(1,0,1,1,1, 0,0, 3'b111, K,K,K, 1,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 5,6, 3'b111, K,K,K, 1,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 5,6, 3'b111, K,K,K, 1,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 5,6, 3'b111, K,K,K, 1,     16'h0,  16'h0, 16'h0, 0,1));
    tv.push_back(mk(1,0,0,0,0, 1,0, 3'b111, K,K,K, 1,     K,      16'h0, K,     0,0));
    tv.push_back(mk(1,0,1,1,3, 1,2, 3'b111, K,K,K, 3,     K,      16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,1,1,3, 1,2, 3'b111, K,K,K, 3,     K,      16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 1,2, 3'b111, K,K,K, 3,     K,      16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 1,2, 3'b111, K,K,16'h1, 3, K,      16'h0, 16'h0, 0,1));
    tv.push_back(mk(1,0,0,0,0, 1,2, 3'b111, K,K,16'h2, 3, K,      16'h0, 16'h1, 0,1));
    tv.push_back(mk(1,0,0,0,0, 3,1, 3'b111, K,K,K, 3,     16'h2,  K,     16'h2, 0,0));
    tv.push_back(mk(1,0,1,1,5, 0,0, 3'b111, K,K,K, 5,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,1,1,6, 0,0, 3'b111, K,K,K, 5,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,1,1,7, 0,0, 3'b111, K,K,K, 5,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,1,0,0,0, 0,0, 3'b111, K,K,16'h55, 5, 16'h0, 16'h0, 16'h0, 0,1));
    tv.push_back(mk(1,0,0,0,0, 5,6, 3'b111, 16'h88,16'h77,16'h66, 5, 16'h55, 16'h0, 16'h55, 0,0));
    tv.push_back(mk(1,0,0,0,0, 7,6, 3'b111, 16'h88,16'h77,16'h66, 6, 16'h0,  16'h0, 16'h0,  0,0));
    tv.push_back(mk(1,0,0,0,0, 7,6, 3'b111, 16'h88,16'h77,16'h66, 7, 16'h0,  16'h0, 16'h0,  0,0));
    tv.push_back(mk(1,1,1,1,2, 0,0, 3'b111, 16'h88,16'h77,16'h66, 2, 16'h0,  16'h0, 16'h0,  0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1,0,0,0,0, 0,2, 3'b111, 16'h88,16'h77,16'h66, 2, 16'h0, 16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,1,1,4, 0,0, 3'b111, K,K,K, 4,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 0,0, 3'b111, K,K,K, 4,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 0,0, 3'b111, K,K,K, 4,     16'h0,  16'h0, 16'h0, 0,0));
    tv.push_back(mk(0,0,1,0,0, 0,0, 3'b011, K,K,16'h444, 4, 16'h0, 16'h0, 16'h0, 1,0));
    tv.push_back(mk(0,0,0,0,0, 0,0, 3'b111, K,K,16'h444, 4, 16'h0, 16'h0, 16'h0, 0,0));
    tv.push_back(mk(1,0,0,0,0, 0,0, 3'b111, K,K,16'h444, 4, 16'h0, 16'h0, 16'h0, 0,1));
    tv.push_back(mk(1,0,0,0,0, 4,0, 3'b111, K,K,16'h444, 4, 16'h444, 16'h0, 16'h444, 0,0));

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].en, tv[i].fl, tv[i].iv, tv[i].we, tv[i].wa, tv[i].ra0, tv[i].ra1,
          tv[i].rdy, tv[i].d0, tv[i].d1, tv[i].d2, tv[i].da);
      chk($sformatf("row%0d_rd0", i),    32'(rd_data[15:0]),  32'(tv[i].e0));
      chk($sformatf("row%0d_rd1", i),    32'(rd_data[31:16]), 32'(tv[i].e1));
      chk($sformatf("row%0d_dbg", i),    32'(dbg_data),       32'(tv[i].edbg));
      chk($sformatf("row%0d_stall", i),  32'(stall),          32'(tv[i].est));
      chk($sformatf("row%0d_commit", i), 32'(commit),         32'(tv[i].ecm));
    end

    // Reset overrides en with a committing writer in the last stage
    cyc(1,0,1,1,1, 0,0, 3'b111, K,K,K, 1);
    idle(0, 1);
    idle(0, 1);
    @(negedge clock);
    reset = 1'b1; en = 1'b1; flush = 1'b0; iss_valid = 1'b1; iss_we = 1'b1;
    iss_waddr = 3'd3; stg_data = {16'h0999, K, K};
    #1 chk("ovr_commit", 32'(commit), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(1,0,1,0,0, 1,3, 3'b111, K,K,K, 1);
    chk("ovr_stall", 32'(stall), 0);
    chk("ovr_rd0", 32'(rd_data[15:0]), 0);
    chk("ovr_dbg1", 32'(dbg_data), 0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 3);
      chk($sformatf("ovr_commit%0d", i), 32'(commit), 0);
    end
    chk("ovr_dbg3", 32'(dbg_data), 0);

    // Reader of an in-flight writer: forwarded per stage, or interlocked 3 cycles
    do_reset();
    cyc(1,0,1,1,4, 0,0, 3'b111, 16'h0a00,16'h0b00,16'h0444, 4);
    chk("fw_issue_stall", 32'(stall), 0);
    cyc(1,0,1,0,0, 4,0, 3'b111, 16'h0a00,16'h0b00,16'h0444, 4);
    chk("fw_a_stall", 32'(stall), BYP ? 0 : 1);
    chk("fw_a_rd0", 32'(rd_data[15:0]), BYP ? 32'h0a00 : 0);
    cyc(1,0,1,0,0, 4,0, 3'b111, 16'h0a00,16'h0b00,16'h0444, 4);
    chk("fw_b_stall", 32'(stall), BYP ? 0 : 1);
    chk("fw_b_rd0", 32'(rd_data[15:0]), BYP ? 32'h0b00 : 0);
    cyc(1,0,1,0,0, 4,0, 3'b111, 16'h0a00,16'h0b00,16'h0444, 4);
    chk("fw_c_stall", 32'(stall), BYP ? 0 : 1);
    chk("fw_c_rd0", 32'(rd_data[15:0]), BYP ? 32'h0444 : 0);
    chk("fw_c_commit", 32'(commit), 1);
    cyc(1,0,1,0,0, 4,0, 3'b111, 16'h0a00,16'h0b00,16'h0444, 4);
    chk("fw_d_stall", 32'(stall), 0);
    chk("fw_d_rd0", 32'(rd_data[15:0]), 32'h0444);
    chk("fw_d_dbg", 32'(dbg_data), 32'h0444);
    chk("fw_d_commit", 32'(commit), 0);

    // Load-use: not-ready producer stalls, stalled issue becomes a bubble
    do_reset();
    cyc(1,0,1,1,2, 0,0, 3'b110, 16'h0d0d,16'h0e0e,K, 2);
    chk("ld_issue_stall", 32'(stall), 0);
    cyc(1,0,1,1,6, 2,0, 3'b110, 16'h0d0d,16'h0e0e,K, 2);
    chk("ld_wait_stall", 32'(stall), 1);
    cyc(1,0,1,1,6, 2,6, 3'b111, 16'h0d0d,16'h0e0e,K, 2);
    chk("ld_rdy_stall", 32'(stall), BYP ? 0 : 1);
    chk("ld_rdy_rd0", 32'(rd_data[15:0]), BYP ? 32'h0e0e : 0);
    chk("ld_bubble_rd1", 32'(rd_data[31:16]), 0);
    for (int i = 0; i < 4; i++) idle(0, 0);

    // Two writers to r3 in flight: younger wins
    do_reset();
    cyc(1,0,1,1,3, 0,0, 3'b111, K,K,K, 3);
    cyc(1,0,1,1,3, 0,0, 3'b111, K,K,K, 3);
    cyc(1,0,1,0,0, 3,0, 3'b111, 16'h0002,16'h0001,16'h0fff, 3);
    chk("ww_stall", 32'(stall), BYP ? 0 : 1);
    chk("ww_rd0", 32'(rd_data[15:0]), BYP ? 32'h0002 : 0);
    cyc(1,0,0,0,0, 3,0, 3'b111, K,16'h0002,16'h0001, 3);
    chk("ww_s1_rd0", 32'(rd_data[15:0]), BYP ? 32'h0002 : 0);
    chk("ww_s1_commit", 32'(commit), 1);
    cyc(1,0,0,0,0, 3,0, 3'b111, K,K,16'h0002, 3);
    chk("ww_s2_rd0", 32'(rd_data[15:0]), BYP ? 32'h0002 : 32'h0001);
    chk("ww_s2_dbg", 32'(dbg_data), 32'h0001);
    chk("ww_s2_commit", 32'(commit), 1);
    cyc(1,0,0,0,0, 3,0, 3'b111, K,K,K, 3);
    chk("ww_final_dbg", 32'(dbg_data), 32'h0002);
    chk("ww_final_commit", 32'(commit), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
